// File: rtl/vx_warp_context.sv
// Per-warp, per-lane register context with combinational operand reads, lane-masked
// writeback and a lane-0 clone engine that stalls reads/writes of the warp it is copying.
//
// state  | meaning
// S_IDLE | engine free, clone_ready high
// S_COPY | copying register idx of lane 0 into masked lanes of warp cw
// S_DONE | single-cycle completion, clone_done high
module vx_warp_context #(
   parameter  int NT = 4,
   parameter  int NW = 8,
   parameter  int NR = 32,
   parameter  int DW = 32,
   localparam int WW = (NW > 1) ? $clog2(NW) : 1,
   localparam int RW = $clog2(NR)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WW-1:0]    rd_warp,
   input  logic [RW-1:0]    rd_src1,
   input  logic [RW-1:0]    rd_src2,
   input  logic             rd_is_jal,
   input  logic [DW-1:0]    rd_pc,
   input  logic             src1_fwd,
   input  logic             src2_fwd,
   input  logic [NT*DW-1:0] src1_fwd_data,
   input  logic [NT*DW-1:0] src2_fwd_data,
   input  logic             wb_valid,
   output logic             wb_ready,
   input  logic [WW-1:0]    wb_warp,
   input  logic [NT-1:0]    wb_mask,
   input  logic [RW-1:0]    wb_rd,
   input  logic [NT*DW-1:0] wb_data,
   input  logic             clone_req,
   output logic             clone_ready,
   input  logic [WW-1:0]    clone_warp,
   input  logic [NT-1:0]    clone_mask,
   output logic             clone_done,
   output logic [NT*DW-1:0] out_a_data,
   output logic [NT*DW-1:0] out_b_data,
   output logic             out_clone_stall
);

   typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] cw;
   logic [NT-1:0] cm;
   logic [RW-1:0] idx;
   logic          busy;
   logic          clone_fire;
   logic          wb_fire;
   logic          last_idx;

   logic [DW-1:0] rf [NW][NT][NR];

   assign busy            = (state != S_IDLE);
   assign last_idx        = (idx == RW'(NR - 1));
   assign wb_ready        = !(busy && (wb_warp == cw));
   assign out_clone_stall = busy && (rd_warp == cw);
   assign clone_fire      = clone_req && clone_ready;
   assign wb_fire         = wb_valid && wb_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clone_ready = 1'b0;
      clone_done  = 1'b0;
      case (state)
         S_IDLE: begin
            clone_ready = 1'b1;
            if (clone_req) state_nxt = S_COPY;
         end
         S_COPY: begin
            if (last_idx) state_nxt = S_DONE;
         end
         S_DONE: begin
            clone_done = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Register 0 is never copied, so the sweep starts at 1 and stops at NR-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cw  <= '0;
         cm  <= '0;
         idx <= '0;
      end else if (clone_fire) begin
         cw  <= clone_warp;
         cm  <= clone_mask;
         idx <= RW'(1);
      end else if (state == S_COPY && !last_idx) begin
         idx <= idx + RW'(1);
      end
   end

   // Writeback never targets cw while busy, so the two write sources cannot collide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int w = 0; w < NW; w++)
            for (int l = 0; l < NT; l++)
               for (int r = 0; r < NR; r++)
                  rf[w][l][r] <= '0;
      end else begin
         if (wb_fire && wb_rd != '0) begin
            for (int l = 0; l < NT; l++)
               if (wb_mask[l]) rf[wb_warp][l][wb_rd] <= wb_data[DW*l +: DW];
         end
         if (state == S_COPY) begin
            for (int l = 0; l < NT; l++)
               if (cm[l]) rf[cw][l][idx] <= rf[cw][0][idx];
         end
      end
   end

   always_comb begin
      out_a_data = '0;
      out_b_data = '0;
      for (int l = 0; l < NT; l++) begin
         if (rd_is_jal)
            out_a_data[DW*l +: DW] = rd_pc;
         else if (src1_fwd)
            out_a_data[DW*l +: DW] = src1_fwd_data[DW*l +: DW];
         else if (rd_src1 != '0)
            out_a_data[DW*l +: DW] = rf[rd_warp][l][rd_src1];

         if (src2_fwd)
            out_b_data[DW*l +: DW] = src2_fwd_data[DW*l +: DW];
         else if (rd_src2 != '0)
            out_b_data[DW*l +: DW] = rf[rd_warp][l][rd_src2];
      end
   end

endmodule
